sr_simd_shift_seq: RTL and testbench

- Multi-cycle sequencer for the packed-SIMD saturating shift ops (KSLL8, KSLLI8, KSLRA8) in the schoolRISCV execute stage.
- Processes one 8-bit lane per cycle through a single shared lane shifter.
- Provides a start/busy/done handshake to the core stall logic.
- Keeps a sticky saturation status bit, readable and clearable by the CSR path.

---
 rtl/sr_simd_pkg.sv | 30 +++
 rtl/sr_simd_shift_seq_if.sv | 31 +++
 rtl/sr_simd_lane.sv | 43 ++++
 rtl/sr_simd_shift_seq.sv | 148 ++++++++++++++
 tb/tb_sr_simd_shift_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sr_simd_pkg.sv
// Shared definitions for the packed-SIMD saturating shift sequencer.
// Contents: default lane geometry, lane saturation limits, the ALU opcode
// values handled here, the sequencer state encoding and an opcode
// classifier.
package sr_simd_pkg;

  localparam int LANE_W_DEF = 8;
  localparam int NLANES_DEF = 4;
  localparam int XLEN       = LANE_W_DEF * NLANES_DEF;

  localparam logic [7:0] SAT_MAX = 8'h7F;
  localparam logic [7:0] SAT_MIN = 8'h80;

  // ALU opcode values matching the core's operation decode
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_KSLL8  = 4'b1100;
  localparam logic [3:0] ALU_KSLLI8 = 4'b1101;
  localparam logic [3:0] ALU_KSLRA8 = 4'b1110;

  // Sequencer states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LANE = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_simd_shift(input logic [3:0] oper);
    return oper inside {ALU_KSLL8, ALU_KSLLI8, ALU_KSLRA8};
  endfunction

endpackage

// File: rtl/sr_simd_shift_seq_if.sv
// Handshake and operand bus between the execute stage and the SIMD shift
// sequencer.
//   master : drives start/oper/srcA/srcB/rounding/kill/ov_clr
//   slave  : drives busy/done/result/ov/ov_sticky/err
interface sr_simd_shift_seq_if;
  import sr_simd_pkg::*;

  logic            start;
  logic [3:0]      oper;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            rounding;
  logic            kill;
  logic            ov_clr;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            ov;
  logic            ov_sticky;
  logic            err;

  modport master (
    output start, oper, srcA, srcB, rounding, kill, ov_clr,
    input  busy, done, result, ov, ov_sticky, err
  );

  modport slave (
    input  start, oper, srcA, srcB, rounding, kill, ov_clr,
    output busy, done, result, ov, ov_sticky, err
  );
endinterface

// File: rtl/sr_simd_lane.sv
// Combinational single-lane shift / round / saturate.
//   x_i        : signed lane value
//   amt_i      : shift magnitude (left 0..7, right 1..8)
//   is_left_i  : 1 = saturating left shift, 0 = arithmetic right shift
//   rounding_i : round-half-up on right shifts
//   y_o        : lane result
//   sat_o      : left shift saturated
module sr_simd_lane
  import sr_simd_pkg::*;
(
  input  logic [7:0] x_i,
  input  logic [3:0] amt_i,
  input  logic       is_left_i,
  input  logic       rounding_i,
  output logic [7:0] y_o,
  output logic       sat_o
);
  logic [15:0] wide;
  logic [8:0]  rnd;
  logic [8:0]  sum;
  logic [7:0]  shr;

  always_comb begin
    wide = {{8{x_i[7]}}, x_i} << amt_i[2:0];
    // 9 bits hold x plus the largest rounding increment (128) without wrap
    rnd  = (rounding_i && amt_i != 4'd0) ? (9'd1 << (amt_i - 4'd1)) : 9'd0;
    sum  = {x_i[7], x_i} + rnd;
    shr  = 8'($signed(sum) >>> amt_i);

    y_o   = shr;
    sat_o = 1'b0;
    if (is_left_i) begin
      y_o = wide[7:0];
      if ($signed(wide) > 16'sd127) begin
        y_o   = SAT_MAX;
        sat_o = 1'b1;
      end else if ($signed(wide) < -16'sd128) begin
        y_o   = SAT_MIN;
        sat_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sr_simd_shift_seq.sv
// Multi-cycle sequencer for KSLL8 / KSLLI8 / KSLRA8. One lane per cycle goes
// through a single shared lane shifter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/kill/ov_clr and operands in; busy/done/result/ov/
//              ov_sticky/err out
//
//   state | meaning
//   IDLE  | waiting for start
//   LANE  | processing lane idx_q, busy high
//   DONE  | done pulse; may accept a new start back-to-back
module sr_simd_shift_seq
  import sr_simd_pkg::*;
#(
  parameter int LANE_W    = LANE_W_DEF,
  parameter int NLANES    = NLANES_DEF,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  sr_simd_shift_seq_if.slave bus
);
  localparam int IDXW = $clog2(NLANES);
  localparam logic [IDXW-1:0] LAST = IDXW'(NLANES - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [3:0]      oper_q, oper_d;
  logic [XLEN-1:0] srca_q, srca_d;
  logic [3:0]      srcb_q, srcb_d;
  logic            rnd_q, rnd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            ov_q, ov_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;

  logic            accept, zero_amt;
  logic [3:0]      lane_amt;
  logic            lane_left;
  logic [7:0]      lane_y;
  logic            lane_sat;

  // Shift direction and magnitude from the captured operands
  always_comb begin
    lane_left = 1'b1;
    lane_amt  = {1'b0, srcb_q[2:0]};
    if (oper_q == ALU_KSLRA8) begin
      lane_amt = srcb_q;
      if (srcb_q[3]) begin
        lane_left = 1'b0;
        lane_amt  = 4'd0 - srcb_q;  // -8 maps to 4'b1000 = 8
      end
    end
  end

  sr_simd_lane u_lane (
    .x_i       (srca_q[LANE_W*idx_q +: LANE_W]),
    .amt_i     (lane_amt),
    .is_left_i (lane_left),
    .rounding_i(rnd_q),
    .y_o       (lane_y),
    .sat_o     (lane_sat)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    oper_d   = oper_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    rnd_d    = rnd_q;
    result_d = result_q;
    ov_d     = ov_q;
    err_d    = err_q;

    accept   = bus.start && (state_q != ST_LANE);
    zero_amt = (bus.oper == ALU_KSLRA8) ? (bus.srcB[3:0] == 4'd0)
                                        : (bus.srcB[2:0] == 3'd0);

    if (bus.kill) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_LANE) begin
      result_d[LANE_W*idx_q +: LANE_W] = lane_y;
      ov_d = ov_q | lane_sat;
      if (idx_q == LAST) state_d = ST_DONE;
      else               idx_d   = idx_q + 1'b1;
    end else begin
      if (state_q == ST_DONE) state_d = ST_IDLE;
      if (accept) begin
        oper_d = bus.oper;
        srca_d = bus.srcA;
        srcb_d = bus.srcB[3:0];
        rnd_d  = bus.rounding;
        idx_d  = '0;
        ov_d   = 1'b0;
        err_d  = 1'b0;
        // An unknown opcode has no defined shift amount, so it is
        // classified before the zero-shift shortcut
        if (!is_simd_shift(bus.oper)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end else if (SKIP_ZERO && zero_amt) begin
          result_d = bus.srcA;
          state_d  = ST_DONE;
        end else begin
          result_d = '0;
          state_d  = ST_LANE;
        end
      end
    end

    sticky_d = (sticky_q & ~bus.ov_clr) |
               ((state_q == ST_DONE) & ov_q & ~bus.kill);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      oper_q   <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      rnd_q    <= 1'b0;
      result_q <= '0;
      ov_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      oper_q   <= oper_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      rnd_q    <= rnd_d;
      result_q <= result_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.busy      = (state_q == ST_LANE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.ov        = ov_q;
  assign bus.err       = err_q & (state_q == ST_DONE);
  assign bus.ov_sticky = sticky_q;
endmodule

// File: tb/tb_sr_simd_shift_seq.sv
module tb_sr_simd_shift_seq;
  import sr_simd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_simd_shift_seq_if bus ();

  sr_simd_shift_seq #(.LANE_W(8), .NLANES(4), .SKIP_ZERO(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] exp_r;
  logic        exp_o, exp_e;
  int          exp_lat;
  int          lat;
  logic        saw_busy;
  logic        sticky_m = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each lane is a signed integer, shifted by multiplying or
  // by floor division by a power of two, then clamped to a signed byte.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic rnd,
                                output logic [31:0] r, output logic o,
                                output logic e, output int lt);
    int sh, x, v, n;
    r = '0; o = 1'b0; e = 1'b0; lt = 5;
    if (!(op == ALU_KSLL8 || op == ALU_KSLLI8 || op == ALU_KSLRA8)) begin
      e = 1'b1; lt = 1;
      return;
    end
    if (op == ALU_KSLRA8) sh = b[3] ? int'(b[3:0]) - 16 : int'(b[3:0]);
    else                  sh = int'(b[2:0]);
    if (sh == 0) begin
      r = a; lt = 1;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      x = $signed(a[8*i +: 8]);
      if (sh > 0) begin
        v = x * (1 << sh);
        if (v > 127)       begin v = 127;  o = 1'b1; end
        else if (v < -128) begin v = -128; o = 1'b1; end
      end else begin
        n = -sh;
        v = x + (rnd ? (1 << (n - 1)) : 0);
        v = v >>> n;
      end
      r[8*i +: 8] = 8'(v);
    end
  endfunction

  task automatic launch(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic rnd);
    model(op, a, b, rnd, exp_r, exp_o, exp_e, exp_lat);
    bus.start = 1'b1; bus.oper = op; bus.srcA = a; bus.srcB = b; bus.rounding = rnd;
    step();
    bus.start = 1'b0;
    bus.oper = 4'($urandom); bus.srcA = $urandom; bus.srcB = $urandom;
    bus.rounding = 1'($urandom_range(0, 1));
    lat = 1;
    saw_busy = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    while (!bus.done && lat < 20) begin
      saw_busy |= bus.busy;
      step();
      lat++;
    end
    chk({tag, "_lat"},    32'(lat),         32'(exp_lat));
    chk({tag, "_result"}, bus.result,       exp_r);
    chk({tag, "_ov"},     32'(bus.ov),      32'(exp_o));
    chk({tag, "_err"},    32'(bus.err),     32'(exp_e));
    chk({tag, "_busy"},   32'(saw_busy),    32'(exp_lat == 5));
  endtask

  task automatic post_done(input string tag, input logic clr);
    bus.ov_clr = clr;
    step();
    bus.ov_clr = 1'b0;
    sticky_m = (sticky_m & ~clr) | exp_o;
    chk({tag, "_sticky"}, 32'(bus.ov_sticky), 32'(sticky_m));
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic rnd);
    launch(op, a, b, rnd);
    wait_done(tag);
    post_done(tag, 1'b0);
  endtask

  initial begin
    logic        saw_done;
    logic [3:0]  rop;
    logic [31:0] rb;

    bus.start = 0; bus.oper = 0; bus.srcA = 0; bus.srcB = 0;
    bus.rounding = 0; bus.kill = 0; bus.ov_clr = 0;
    step(); step();
    chk("rst_busy",   32'(bus.busy),      0);
    chk("rst_done",   32'(bus.done),      0);
    chk("rst_result", bus.result,         0);
    chk("rst_ov",     32'(bus.ov),        0);
    chk("rst_err",    32'(bus.err),       0);
    chk("rst_sticky", 32'(bus.ov_sticky), 0);
    rst = 1'b0;
    step();

    // Directed cases
    run("ksll8_sat",    ALU_KSLL8,  32'h7F01C040, 32'h1, 1'b0);
    chk("t1_const",     exp_r, 32'h7F02807F);
    run("ksra_r1",      ALU_KSLRA8, 32'h03FF817F, 32'hF, 1'b1);
    chk("t2a_const",    exp_r, 32'h0200C140);
    run("ksra_r0",      ALU_KSLRA8, 32'h03FF817F, 32'hF, 1'b0);
    chk("t2b_const",    exp_r, 32'h01FFC03F);
    run("ksra8_r0",     ALU_KSLRA8, 32'h807F01FF, 32'h8, 1'b0);
    chk("t3a_const",    exp_r, 32'hFF0000FF);
    run("ksra8_r1",     ALU_KSLRA8, 32'h807F01FF, 32'h8, 1'b1);
    run("zero_shift",   ALU_KSLL8,  32'h12345678, 32'h0, 1'b0);
    run("ksrai_pos",    ALU_KSLRA8, 32'h10F0207F, 32'h7, 1'b0);
    run("kslli8",       ALU_KSLLI8, 32'h01FF0880, 32'h3, 1'b0);
    run("unsupported",  ALU_ADD,    32'hDEADBEEF, 32'h5, 1'b0);

    // Start while busy is ignored
    launch(ALU_KSLL8, 32'h11223344, 32'h2, 1'b0);
    bus.start = 1'b1; bus.oper = ALU_KSLRA8; bus.srcA = 32'hFFFFFFFF; bus.srcB = 32'hC;
    step(); lat++;
    bus.start = 1'b0;
    wait_done("ign_start");
    post_done("ign_start", 1'b0);

    // Kill mid-operation
    launch(ALU_KSLL8, 32'h7F7F7F7F, 32'h1, 1'b0);
    step();
    bus.kill = 1'b1; bus.start = 1'b1;
    step();
    bus.kill = 1'b0; bus.start = 1'b0;
    chk("kill_busy", 32'(bus.busy), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_done |= bus.done;
      step();
    end
    chk("kill_no_done", 32'(saw_done), 0);
    chk("kill_sticky",  32'(bus.ov_sticky), 32'(sticky_m));

    // Reset during lane 2
    launch(ALU_KSLL8, 32'h7F7F7F7F, 32'h1, 1'b0);
    step(); step();
    rst = 1'b1;
    #1;
    chk("arst_busy",   32'(bus.busy),      0);
    chk("arst_result", bus.result,         0);
    chk("arst_sticky", 32'(bus.ov_sticky), 0);
    sticky_m = 1'b0;
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_done |= bus.done;
      step();
    end
    chk("arst_no_done", 32'(saw_done), 0);

    // Sticky set wins over clear; clear alone; back-to-back
    launch(ALU_KSLL8, 32'h7F01C040, 32'h1, 1'b0);
    wait_done("set_vs_clr");
    post_done("set_vs_clr", 1'b1);
    chk("set_vs_clr_one", 32'(bus.ov_sticky), 1);
    exp_o = 1'b0;
    post_done("clr_only", 1'b1);
    launch(ALU_KSLRA8, 32'h40C00102, 32'h3, 1'b0);
    wait_done("b2b_first");
    sticky_m |= exp_o;
    launch(ALU_KSLL8, 32'h01020304, 32'h4, 1'b0);
    wait_done("b2b_second");
    post_done("b2b_second", 1'b0);

    // Randomized operations
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 4))
        0:       rop = ALU_KSLL8;
        1:       rop = ALU_KSLLI8;
        2, 3:    rop = ALU_KSLRA8;
        default: rop = ALU_ADD;
      endcase
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb[3:0] = 4'd0;
      run($sformatf("rand%0d", k), rop, $urandom, rb, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
